// File: rtl/bcd_countdown_timer_pkg.sv
// ============================================================================
// Module : microwave_timer_pkg
// Brief  : Shared state type, digit limits and per-digit maximum helper for
//          the BCD countdown timer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package microwave_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Digit 1 is the seconds-tens digit in mm:ss mode
  function automatic logic [3:0] digit_max(input int index, input logic mmss);
    return (mmss && (index == 1)) ? SEC_TENS_MAX : BCD_MAX;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_countdown_timer_digit.sv
// ============================================================================
// Module : bcd_digit_down
// Brief  : One BCD down-counting digit with saturating load and borrow wrap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_down #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       ld,
  input  logic [3:0] d,
  input  logic       dec,
  input  logic       borrow_in,
  output logic [3:0] q,
  output logic       borrow_out,
  output logic       is_zero
);

  logic [3:0] r_q;
  logic [3:0] w_d_sat;

  assign w_d_sat = (d > MAX) ? MAX : d;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_q <= 4'd0;
    end else if (ld) begin
      r_q <= w_d_sat;
    end else if (dec && borrow_in) begin
      r_q <= (r_q == 4'd0) ? MAX : (r_q - 4'd1);
    end
  end

  assign q          = r_q;
  assign is_zero    = (r_q == 4'd0);
  assign borrow_out = borrow_in && is_zero;

endmodule

`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
// ============================================================================
// Module : bcd_countdown_timer
// Brief  : Multi-digit BCD countdown timer with IDLE/RUN/PAUSED/DONE control.
//          Define QUICK_ADD_EN to add the add30 quick-add input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_countdown_timer
  import microwave_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MMSS       = 1
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    tick,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    start,
  input  logic                    pause,
`ifdef QUICK_ADD_EN
  input  logic                    add30,
`endif
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    running,
  output logic                    done,
  output logic                    zero
);

  localparam int W = 4 * NUM_DIGITS;

  timer_state_t          r_state;
  logic                  r_running;
  logic                  r_done;
  logic [NUM_DIGITS-1:0] w_is_zero;
  logic [NUM_DIGITS:0]   w_borrow;
  logic [W-1:0]          w_count;
  logic [W-1:0]          w_ld_data;
  logic                  w_ld;
  logic                  w_add;
  logic                  w_dec;
  logic                  w_zero;
  logic                  w_is_one;

`ifdef QUICK_ADD_EN
  logic [W-1:0] w_add_sum;
  logic [4:0]   w_sum;
  logic [4:0]   w_lim;
  logic         w_carry;

  // +30 lands on digit 1; carry ripples upward and saturates at all-max
  always_comb begin
    w_add_sum = w_count;
    w_sum     = 5'd0;
    w_lim     = 5'd0;
    w_carry   = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      w_lim = {1'b0, digit_max(i, MMSS != 0)};
      w_sum = {1'b0, w_count[4*i +: 4]} + ((i == 1) ? 5'd3 : 5'd0) + {4'd0, w_carry};
      if (w_sum > w_lim) begin
        w_sum   = w_sum - (w_lim + 5'd1);
        w_carry = 1'b1;
      end else begin
        w_carry = 1'b0;
      end
      w_add_sum[4*i +: 4] = w_sum[3:0];
    end
    if (w_carry) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        w_add_sum[4*i +: 4] = digit_max(i, MMSS != 0);
      end
    end
  end

  assign w_add     = load && add30;
  assign w_ld      = !load || add30;
  assign w_ld_data = !load ? data : w_add_sum;
`else
  assign w_add     = 1'b0;
  assign w_ld      = !load;
  assign w_ld_data = data;
`endif

  assign w_borrow[0] = 1'b1;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit_down #(
        .MAX (digit_max(i, MMSS != 0))
      ) u_digit (
        .clk        (clk),
        .clear      (clear),
        .ld         (w_ld),
        .d          (w_ld_data[4*i +: 4]),
        .dec        (w_dec),
        .borrow_in  (w_borrow[i]),
        .q          (w_count[4*i +: 4]),
        .borrow_out (w_borrow[i+1]),
        .is_zero    (w_is_zero[i])
      );
    end
  endgenerate

  // Borrow out of the top digit is set exactly when every digit is zero
  assign w_zero   = w_borrow[NUM_DIGITS];
  assign w_is_one = !w_is_zero[0] && (w_count[3:1] == 3'd0) && (&w_is_zero[NUM_DIGITS-1:1]);
  assign w_dec    = load && (r_state == RUN) && tick && !pause && !start && !w_add && !w_zero;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!load) begin
        r_state   <= IDLE;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && !pause && !w_zero) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              r_state   <= PAUSED;
              r_running <= 1'b0;
            end else if (w_dec && w_is_one) begin
              r_state   <= DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end
          end
          PAUSED: begin
            if (start && !pause) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          DONE: begin
            if (w_add) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count   = w_count;
  assign running = r_running;
  assign done    = r_done;
  assign zero    = w_zero;

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
// ============================================================================
// Module : tb_bcd_countdown_timer
// Brief  : Scoreboard bench for bcd_countdown_timer (4 digits, mm:ss), with a
//          seconds-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_countdown_timer;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;
  localparam int MAXV   = 99 * 60 + 59;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        tick = 1'b0;
  logic        load = 1'b1;
  logic [15:0] data = 16'h0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        add_in = 1'b0;
  logic [15:0] count;
  logic        running, done, zero;

  int n_cmp = 0;
  int n_bad = 0;
  int mval = 0;
  int mst = S_IDLE;
  bit mdone = 1'b0;
  logic [18:0] exp_q[$];

  bcd_countdown_timer #(.NUM_DIGITS(4), .MMSS(1)) dut (
    .clk     (clk),
    .clear   (clear),
    .tick    (tick),
    .load    (load),
    .data    (data),
    .start   (start),
    .pause   (pause),
`ifdef QUICK_ADD_EN
    .add30   (add_in),
`endif
    .count   (count),
    .running (running),
    .done    (done),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  function automatic int to_val(input logic [15:0] b);
    return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    int m, s;
    m = v / 60;
    s = v % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] sanit(input logic [15:0] d);
    logic [15:0] r;
    logic [3:0]  mx;
    r = d;
    for (int i = 0; i < 4; i++) begin
      mx = (i == 1) ? 4'd5 : 4'd9;
      if (r[4*i +: 4] > mx) r[4*i +: 4] = mx;
    end
    return r;
  endfunction

  task automatic model_step(input logic ld_n, input logic [15:0] d,
                            input logic st, input logic ps, input logic tk, input logic ad);
    int pre;
    mdone = 1'b0;
    if (!ld_n) begin
      mval = to_val(sanit(d));
      mst  = S_IDLE;
    end else begin
      pre = mval;
      if (ad) mval = (mst == S_DONE) ? 30 : ((mval + 30 > MAXV) ? MAXV : mval + 30);
      case (mst)
        S_IDLE:   if (st && !ps && pre != 0) mst = S_RUN;
        S_RUN: begin
          if (ps) mst = S_PAUSED;
          else if (!st && tk && !ad && mval > 0) begin
            mval = mval - 1;
            if (mval == 0) begin
              mst   = S_DONE;
              mdone = 1'b1;
            end
          end
        end
        S_PAUSED: if (st && !ps) mst = S_RUN;
        default:  if (ad) mst = S_RUN;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic ld_n, input logic [15:0] d,
                     input logic st, input logic ps, input logic tk, input logic ad);
    @(negedge clk);
    load = ld_n; data = d; start = st; pause = ps; tick = tk; add_in = ad;
    model_step(ld_n, d, st, ps, tk, ad);
    exp_q.push_back({to_bcd(mval), mst == S_RUN, mdone, mval == 0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_next(input string name, input logic [15:0] exp);
    @(posedge clk);
    #1;
    chk(name, {16'h0, count}, {16'h0, exp});
  endtask

  task automatic clear_mid();
    @(negedge clk);
    load = 1'b1; start = 1'b0; pause = 1'b0; tick = 1'b0; add_in = 1'b0;
    #2 clear = 1'b0;
    #1;
    chk("async_clear", {13'h0, count, running, done, zero}, {13'h0, 16'h0, 1'b0, 1'b0, 1'b1});
    mval = 0; mst = S_IDLE; mdone = 1'b0;
    @(negedge clk);
    clear = 1'b1;
  endtask

  // Monitor: one expected response per clock, compared just after the edge
  initial begin
    logic [18:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({count, running, done, zero} !== e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: count=%h run=%b done=%b zero=%b expected count=%h run=%b done=%b zero=%b",
                   $time, count, running, done, zero, e[18:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ld_n, st, ps, tk, ad;
    logic [15:0] d;
    #1 clear = 1'b0;
    #1 chk("reset", {13'h0, count, running, done, zero}, {13'h0, 16'h0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    clear = 1'b1;

    cyc(1'b0, 16'h0130, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_next("first_tick", 16'h0129);
    chk("running_high", {31'h0, running}, 32'h1);

    cyc(1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_next("mod6_borrow", 16'h0059);

    cyc(1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    cyc(1'b0, 16'h0A7F, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_next("sanitise", 16'h0959);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    cyc(1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_next("resume_tick", 16'h0009);

    cyc(1'b0, 16'h0500, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    clear_mid();
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 800; n++) begin
      ld_n = ($urandom_range(0, 24) != 0);
      d    = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      st   = ($urandom_range(0, 5) == 0);
      ps   = ($urandom_range(0, 9) == 0);
      tk   = ($urandom_range(0, 1) == 1);
`ifdef QUICK_ADD_EN
      ad   = ($urandom_range(0, 19) == 0);
`else
      ad   = 1'b0;
`endif
      if (n == 400) clear_mid();
      cyc(ld_n, d, st, ps, tk, ad);
    end

    idle(2);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
